standoff_round_ctrl: RTL and testbench

Round sequencer for the two-player standoff game. Each round it collects one move per player within a timed window, reveals both moves, then resolves ammo and lives and decides game over. Its `p1_dchoice`, `p2_dchoice`, `p1lives` and `p2lives` outputs drive the 8-digit score display directly, using the display's glyph codes.

---
 rtl/standoff_pkg.sv | 57 +++++
 rtl/standoff_timer.sv | 25 ++
 rtl/standoff_round_ctrl.sv | 165 ++++++++++++++++
 tb/tb_standoff_round_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/standoff_pkg.sv
// Shared definitions for the standoff round controller: move codes, display glyphs,
// FSM states, winner codes and the pure round-resolution function.
package standoff_pkg;

    localparam logic [1:0] MV_NONE   = 2'd0;
    localparam logic [1:0] MV_DUCK   = 2'd1;
    localparam logic [1:0] MV_RELOAD = 2'd2;
    localparam logic [1:0] MV_SHOOT  = 2'd3;

    localparam logic [3:0] GLYPH_IDLE   = 4'd10;
    localparam logic [3:0] GLYPH_DUCK   = 4'd11;
    localparam logic [3:0] GLYPH_RELOAD = 4'd12;
    localparam logic [3:0] GLYPH_SHOOT  = 4'd13;
    localparam logic [3:0] GLYPH_PLAYER = 4'd14;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {IDLE, COLLECT, REVEAL, RESOLVE, OVER} state_t;

    typedef struct packed {
        logic [1:0] p1_lives;
        logic [1:0] p2_lives;
        logic       p1_ammo;
        logic       p2_ammo;
    } round_result_t;

    function automatic logic [3:0] move_glyph(input logic [1:0] mv);
        case (mv)
            MV_DUCK:   return GLYPH_DUCK;
            MV_RELOAD: return GLYPH_RELOAD;
            MV_SHOOT:  return GLYPH_SHOOT;
            default:   return GLYPH_IDLE;
        endcase
    endfunction

    // Both players are judged on pre-round ammo, so simultaneous hits both land.
    function automatic round_result_t resolve_round(
        input logic [1:0] m1, input logic [1:0] m2,
        input logic       a1, input logic       a2,
        input logic [1:0] l1, input logic [1:0] l2);
        round_result_t r;
        logic fire1, fire2, hit1, hit2;
        fire1 = (m1 == MV_SHOOT) && a1;
        fire2 = (m2 == MV_SHOOT) && a2;
        hit2  = fire1 && (m2 != MV_DUCK);
        hit1  = fire2 && (m1 != MV_DUCK);
        r.p1_lives = (hit1 && l1 != 2'd0) ? l1 - 2'd1 : l1;
        r.p2_lives = (hit2 && l2 != 2'd0) ? l2 - 2'd1 : l2;
        r.p1_ammo  = (m1 == MV_RELOAD) ? 1'b1 : (fire1 ? 1'b0 : a1);
        r.p2_ammo  = (m2 == MV_RELOAD) ? 1'b1 : (fire2 ? 1'b0 : a2);
        return r;
    endfunction

endpackage

// File: rtl/standoff_timer.sv
// Loadable down-counter shared by the collect and reveal windows; done is high
// while enabled on the final count.
module standoff_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] load_val,
    output logic        done
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 32'd1;
    end

    assign done = en && (count == '0);

endmodule

// File: rtl/standoff_round_ctrl.sv
// Round sequencer for the two-player standoff game: collects hidden moves, reveals
// them, resolves ammo and lives, and flags game over with a winner.
module standoff_round_ctrl
    import standoff_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int CHOICE_CYCLES = 300_000_000,
    parameter int REVEAL_CYCLES = 200_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic [3:0] p1_dchoice,
    output logic [3:0] p2_dchoice,
    output logic [1:0] p1lives,
    output logic [1:0] p2lives,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [1:0]  LIVES0      = 2'(INIT_LIVES);
    localparam logic [31:0] CHOICE_LOAD = 32'(CHOICE_CYCLES - 1);
    localparam logic [31:0] REVEAL_LOAD = 32'(REVEAL_CYCLES - 1);

    state_t        state, state_nxt;
    logic [1:0]    p1_mv, p2_mv, p1_mv_nxt, p2_mv_nxt;
    logic          p1_lock, p2_lock, p1_lock_nxt, p2_lock_nxt;
    logic          p1_ammo, p2_ammo, p1_ammo_nxt, p2_ammo_nxt;
    logic [3:0]    p1_dchoice_nxt, p2_dchoice_nxt;
    logic [1:0]    p1lives_nxt, p2lives_nxt, winner_nxt;
    logic          game_over_nxt;
    logic          p1_take, p2_take, timer_done, timer_clr;
    round_result_t res;

    // Only the first nonzero move of a round is taken for each player.
    assign p1_take = p1_valid && (p1_move != MV_NONE) && !p1_lock;
    assign p2_take = p2_valid && (p2_move != MV_NONE) && !p2_lock;
    assign res     = resolve_round(p1_mv, p2_mv, p1_ammo, p2_ammo, p1lives, p2lives);

    assign timer_clr = (state_nxt != state);

    standoff_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (timer_clr),
        .en       ((state == COLLECT) || (state == REVEAL)),
        .load_val ((state_nxt == REVEAL) ? REVEAL_LOAD : CHOICE_LOAD),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            p1_mv      <= MV_NONE;
            p2_mv      <= MV_NONE;
            p1_lock    <= 1'b0;
            p2_lock    <= 1'b0;
            p1_ammo    <= 1'b0;
            p2_ammo    <= 1'b0;
            p1_dchoice <= GLYPH_IDLE;
            p2_dchoice <= GLYPH_IDLE;
            p1lives    <= LIVES0;
            p2lives    <= LIVES0;
            game_over  <= 1'b0;
            winner     <= WIN_NONE;
        end else begin
            state      <= state_nxt;
            p1_mv      <= p1_mv_nxt;
            p2_mv      <= p2_mv_nxt;
            p1_lock    <= p1_lock_nxt;
            p2_lock    <= p2_lock_nxt;
            p1_ammo    <= p1_ammo_nxt;
            p2_ammo    <= p2_ammo_nxt;
            p1_dchoice <= p1_dchoice_nxt;
            p2_dchoice <= p2_dchoice_nxt;
            p1lives    <= p1lives_nxt;
            p2lives    <= p2lives_nxt;
            game_over  <= game_over_nxt;
            winner     <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, OVER: if (start) state_nxt = COLLECT;
            COLLECT: if (((p1_lock || p1_take) && (p2_lock || p2_take)) || timer_done)
                         state_nxt = REVEAL;
            REVEAL:  if (timer_done) state_nxt = RESOLVE;
            RESOLVE: state_nxt = (res.p1_lives == 2'd0 || res.p2_lives == 2'd0) ? OVER : COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        p1_mv_nxt      = p1_mv;
        p2_mv_nxt      = p2_mv;
        p1_lock_nxt    = p1_lock;
        p2_lock_nxt    = p2_lock;
        p1_ammo_nxt    = p1_ammo;
        p2_ammo_nxt    = p2_ammo;
        p1_dchoice_nxt = p1_dchoice;
        p2_dchoice_nxt = p2_dchoice;
        p1lives_nxt    = p1lives;
        p2lives_nxt    = p2lives;
        game_over_nxt  = game_over;
        winner_nxt     = winner;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    p1_mv_nxt      = MV_NONE;
                    p2_mv_nxt      = MV_NONE;
                    p1_lock_nxt    = 1'b0;
                    p2_lock_nxt    = 1'b0;
                    p1_ammo_nxt    = 1'b0;
                    p2_ammo_nxt    = 1'b0;
                    p1_dchoice_nxt = GLYPH_IDLE;
                    p2_dchoice_nxt = GLYPH_IDLE;
                    p1lives_nxt    = LIVES0;
                    p2lives_nxt    = LIVES0;
                    game_over_nxt  = 1'b0;
                    winner_nxt     = WIN_NONE;
                end
            end
            COLLECT: begin
                if (p1_take) begin
                    p1_lock_nxt = 1'b1;
                    p1_mv_nxt   = p1_move;
                end
                if (p2_take) begin
                    p2_lock_nxt = 1'b1;
                    p2_mv_nxt   = p2_move;
                end
                // Glyphs are registered on the way into REVEAL, including a last-cycle move.
                if (state_nxt == REVEAL) begin
                    p1_dchoice_nxt = move_glyph(p1_take ? p1_move : p1_mv);
                    p2_dchoice_nxt = move_glyph(p2_take ? p2_move : p2_mv);
                end
            end
            RESOLVE: begin
                p1_ammo_nxt = res.p1_ammo;
                p2_ammo_nxt = res.p2_ammo;
                p1lives_nxt = res.p1_lives;
                p2lives_nxt = res.p2_lives;
                if (state_nxt == OVER) begin
                    game_over_nxt = 1'b1;
                    winner_nxt    = {res.p1_lives == 2'd0, res.p2_lives == 2'd0};
                end else begin
                    p1_mv_nxt      = MV_NONE;
                    p2_mv_nxt      = MV_NONE;
                    p1_lock_nxt    = 1'b0;
                    p2_lock_nxt    = 1'b0;
                    p1_dchoice_nxt = GLYPH_IDLE;
                    p2_dchoice_nxt = GLYPH_IDLE;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_standoff_round_ctrl.sv
// Self-checking bench for standoff_round_ctrl: directed game scenarios plus random
// rounds, all judged against a round-level game model kept in the bench.
module tb_standoff_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       p1_valid = 1'b0, p2_valid = 1'b0;
    logic [1:0] p1_move = 2'd0, p2_move = 2'd0;
    logic [3:0] p1_dchoice, p2_dchoice;
    logic [1:0] p1lives, p2lives, winner;
    logic       game_over;

    int total = 0;
    int bad = 0;

    int m_l1, m_l2, m_a1, m_a2;
    bit m_over;

    localparam int NONE = 99;

    standoff_round_ctrl #(
        .INIT_LIVES(3), .CHOICE_CYCLES(20), .REVEAL_CYCLES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .p1_valid(p1_valid), .p1_move(p1_move),
        .p2_valid(p2_valid), .p2_move(p2_move),
        .p1_dchoice(p1_dchoice), .p2_dchoice(p2_dchoice),
        .p1lives(p1lives), .p2lives(p2lives),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_new_game();
        m_l1 = 3; m_l2 = 3; m_a1 = 0; m_a2 = 0; m_over = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        total++;
        if ({p1_dchoice, p2_dchoice, p1lives, p2lives, game_over, winner} !==
            {4'd10, 4'd10, 2'd3, 2'd3, 1'b0, 2'd0}) begin
            bad++;
            $display("[TB] FAIL reset_values got=%h exp=%h",
                     {p1_dchoice, p2_dchoice, p1lives, p2lives, game_over, winner},
                     {4'd10, 4'd10, 2'd3, 2'd3, 1'b0, 2'd0});
        end
        rst_n = 1'b1;
        model_new_game();
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_new_game();
        total++;
        if ({p1lives, p2lives, game_over, winner, p1_dchoice, p2_dchoice} !==
            {2'd3, 2'd3, 1'b0, 2'd0, 4'd10, 4'd10}) begin
            bad++;
            $display("[TB] FAIL start_load got lives=%0d/%0d over=%0d win=%0d glyph=%0d/%0d exp 3/3 0 0 10/10",
                     p1lives, p2lives, game_over, winner, p1_dchoice, p2_dchoice);
        end
    endtask

    // Called on the first COLLECT cycle; d1/d2 are press offsets, NONE means no press.
    task automatic play_round(input logic [1:0] mv1, input logic [1:0] mv2,
                              input int d1, input int d2, input int extra1);
        bit         lk1, lk2, f1, f2;
        int         exit_t;
        logic [1:0] e1, e2;
        logic [3:0] g1, g2;
        lk1 = (d1 < 20) && (mv1 != 2'd0);
        lk2 = (d2 < 20) && (mv2 != 2'd0);
        exit_t = (lk1 && lk2) ? ((d1 > d2) ? d1 : d2) : 19;
        e1 = lk1 ? mv1 : 2'd0;
        e2 = lk2 ? mv2 : 2'd0;
        g1 = 4'd10 + {2'b00, e1};
        g2 = 4'd10 + {2'b00, e2};
        for (int t = 0; t <= exit_t; t++) begin
            p1_valid = (t == d1) || (t == extra1);
            p1_move  = (t == extra1) ? 2'd3 : mv1;
            p2_valid = (t == d2);
            p2_move  = mv2;
            total++;
            if ({p1_dchoice, p2_dchoice} !== {4'd10, 4'd10}) begin
                bad++;
                $display("[TB] FAIL hidden_glyph t=%0d got=%0d/%0d exp=10/10", t, p1_dchoice, p2_dchoice);
            end
            tick();
        end
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        for (int r = 0; r < 5; r++) begin
            total++;
            if ({p1_dchoice, p2_dchoice} !== {g1, g2}) begin
                bad++;
                $display("[TB] FAIL reveal_glyph r=%0d got=%0d/%0d exp=%0d/%0d", r, p1_dchoice, p2_dchoice, g1, g2);
            end
            tick();
        end
        total++;
        if ({p1lives, p2lives} !== {2'(m_l1), 2'(m_l2)}) begin
            bad++;
            $display("[TB] FAIL resolve_hold got=%0d/%0d exp=%0d/%0d", p1lives, p2lives, m_l1, m_l2);
        end
        tick();
        f1 = (e1 == 2'd3) && (m_a1 == 1);
        f2 = (e2 == 2'd3) && (m_a2 == 1);
        if (f1 && e2 != 2'd1 && m_l2 > 0) m_l2 = m_l2 - 1;
        if (f2 && e1 != 2'd1 && m_l1 > 0) m_l1 = m_l1 - 1;
        m_a1 = (e1 == 2'd2) ? 1 : (f1 ? 0 : m_a1);
        m_a2 = (e2 == 2'd2) ? 1 : (f2 ? 0 : m_a2);
        m_over = (m_l1 == 0) || (m_l2 == 0);
        total++;
        if ({p1lives, p2lives, game_over, winner} !==
            {2'(m_l1), 2'(m_l2), m_over, m_l1 == 0, m_l2 == 0}) begin
            bad++;
            $display("[TB] FAIL round_result got lives=%0d/%0d over=%0d win=%0d exp lives=%0d/%0d over=%0d win=%0d",
                     p1lives, p2lives, game_over, winner, m_l1, m_l2, m_over, {m_l1 == 0, m_l2 == 0});
        end
        total++;
        if ({p1_dchoice, p2_dchoice} !== (m_over ? {g1, g2} : {4'd10, 4'd10})) begin
            bad++;
            $display("[TB] FAIL post_round_glyph got=%0d/%0d over=%0d", p1_dchoice, p2_dchoice, m_over);
        end
    endtask

    task automatic test_reload_duck();
        do_start();
        play_round(2'd2, 2'd1, 3, 5, NONE);
    endtask

    task automatic test_shoot_and_misfire();
        play_round(2'd3, 2'd2, 0, 4, NONE);
        play_round(2'd3, 2'd2, 6, 1, NONE);
    endtask

    task automatic test_double_hit();
        play_round(2'd2, 2'd2, 2, 2, NONE);
        play_round(2'd3, 2'd3, 1, 3, NONE);
        play_round(2'd2, 2'd2, 0, 0, NONE);
        play_round(2'd2, 2'd3, 4, 2, NONE);
        play_round(2'd1, 2'd2, 3, 7, NONE);
        play_round(2'd3, 2'd3, 5, 5, NONE);
    endtask

    task automatic test_timeout();
        do_start();
        play_round(2'd1, 2'd0, 2, NONE, 6);
    endtask

    task automatic test_p1_wins();
        for (int k = 0; k < 3; k++) begin
            play_round(2'd2, 2'd2, 1, 2, NONE);
            play_round(2'd3, 2'd2, 2, 1, NONE);
        end
        do_start();
    endtask

    task automatic test_reset_in_reveal();
        p1_valid = 1'b1; p1_move = 2'd3;
        p2_valid = 1'b1; p2_move = 2'd1;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({p1_dchoice, p2_dchoice, game_over} !== {4'd13, 4'd11, 1'b0}) begin
            bad++;
            $display("[TB] FAIL start_in_reveal got=%0d/%0d over=%0d exp=13/11 0", p1_dchoice, p2_dchoice, game_over);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({p1_dchoice, p2_dchoice, p1lives, p2lives, game_over} !==
            {4'd10, 4'd10, 2'd3, 2'd3, 1'b0}) begin
            bad++;
            $display("[TB] FAIL async_reset got glyph=%0d/%0d lives=%0d/%0d over=%0d",
                     p1_dchoice, p2_dchoice, p1lives, p2lives, game_over);
        end
        #2 rst_n = 1'b1;
        model_new_game();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] r1, r2;
        int         q1, q2;
        do_start();
        for (int n = 0; n < 40; n++) begin
            if (m_over) do_start();
            r1 = 2'($urandom_range(0, 3));
            r2 = 2'($urandom_range(0, 3));
            q1 = ($urandom_range(0, 4) == 0) ? NONE : int'($urandom_range(0, 19));
            q2 = ($urandom_range(0, 4) == 0) ? NONE : int'($urandom_range(0, 19));
            play_round(r1, r2, q1, q2, NONE);
        end
    endtask

    initial begin
        test_reset();
        test_reload_duck();
        test_shoot_and_misfire();
        test_double_hit();
        test_timeout();
        test_p1_wins();
        test_reset_in_reveal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
